filter_arbiter: RTL and testbench

//  Round-robin arbiter between NUM_FILTER Filter_Logic buffers (one Filter_Bank) and one force pipeline.

---
 rtl/filter_pkg.sv | 47 ++++
 rtl/filter_arb_out_fifo.sv | 82 ++++++++
 rtl/filter_arbiter.sv | 163 ++++++++++++++++
 tb/tb_filter_arbiter.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/filter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : filter_pkg
// Description : Shared definitions for the filter arbiter. Provides the
//               particle-pair width and the bit offsets of each field within
//               a pair {ref_id, neighbor_id, r2, dz, dy, dx} (MSB->LSB).
// Revision    : 1.0 - initial release
// ============================================================================
package filter_pkg;

    localparam int DATA_WIDTH_DEF        = 32;
    localparam int PARTICLE_ID_WIDTH_DEF = 20;

    // Total width of one particle pair.
    function automatic int pair_width(input int dw, input int pw);
        return 2 * pw + 4 * dw;
    endfunction

    // Field LSB offsets inside a pair.
    function automatic int dx_lsb(input int dw);
        return 0 * dw;
    endfunction

    function automatic int dy_lsb(input int dw);
        return 1 * dw;
    endfunction

    function automatic int dz_lsb(input int dw);
        return 2 * dw;
    endfunction

    function automatic int r2_lsb(input int dw);
        return 3 * dw;
    endfunction

    function automatic int nbr_id_lsb(input int dw);
        return 4 * dw;
    endfunction

    function automatic int ref_id_lsb(input int dw, input int pw);
        return 4 * dw + pw;
    endfunction

    localparam int PAIR_WIDTH_DEF = pair_width(DATA_WIDTH_DEF, PARTICLE_ID_WIDTH_DEF);

endpackage : filter_pkg
`default_nettype wire

// File: rtl/filter_arb_out_fifo.sv
`default_nettype none
// ============================================================================
// Module      : filter_arb_out_fifo
// Description : Show-ahead synchronous FIFO holding {filter_id, pair} entries
//               between the arbiter capture stage and the force pipeline.
//               rd_data_o always presents the head entry; a read pops it.
// Ports       : clk, rst (async, active-low), wr_i/wr_data_i (push),
//               rd_i (pop), rd_data_o (head), empty_o, full_o, count_o
// Revision    : 1.0 - initial release
// ============================================================================
module filter_arb_out_fifo #(
    parameter int WIDTH      = 171,
    parameter int DEPTH      = 4,
    parameter int ADDR_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  wr_i,
    input  logic [WIDTH-1:0]      wr_data_i,
    input  logic                  rd_i,
    output logic [WIDTH-1:0]      rd_data_o,
    output logic                  empty_o,
    output logic                  full_o,
    output logic [ADDR_WIDTH:0]   count_o
);

    localparam logic [ADDR_WIDTH-1:0] c_LAST_ADDR = ADDR_WIDTH'(DEPTH - 1);
    localparam logic [ADDR_WIDTH:0]   c_DEPTH     = (ADDR_WIDTH + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem_q [DEPTH];
    logic [ADDR_WIDTH-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_WIDTH-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic                  w_do_wr;
    logic                  w_do_rd;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == c_DEPTH);
    assign count_o   = count_q;
    assign rd_data_o = mem_q[rd_ptr_q];

    assign w_do_wr = wr_i & ~full_o;
    assign w_do_rd = rd_i & ~empty_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (w_do_wr) begin
            wr_ptr_d = (wr_ptr_q == c_LAST_ADDR) ? '0 : wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (w_do_rd) begin
            rd_ptr_d = (rd_ptr_q == c_LAST_ADDR) ? '0 : rd_ptr_q + ADDR_WIDTH'(1);
        end
        case ({w_do_wr, w_do_rd})
            2'b10:   count_d = count_q + (ADDR_WIDTH + 1)'(1);
            2'b01:   count_d = count_q - (ADDR_WIDTH + 1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage needs no reset: an entry is only visible once count covers it.
    always_ff @(posedge clk) begin
        if (w_do_wr) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

endmodule : filter_arb_out_fifo
`default_nettype wire

// File: rtl/filter_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : filter_arbiter
// Description : Round-robin arbiter between NUM_FILTER filter buffers and a
//               single force pipeline. Issues a one-hot read request (sel),
//               captures the addressed pair one cycle later and queues it,
//               with its source filter id, in a small show-ahead FIFO.
//               A credit counter (reserved) covers both in-flight and queued
//               pairs so the FIFO can never overflow.
// Ports       : clk, rst (async, active-low), enable, pair_available,
//               pair_data, sel, out_valid, out_ready, out_pair,
//               out_filter_id, idle
// Revision    : 1.0 - initial release
// ============================================================================
module filter_arbiter
    import filter_pkg::*;
#(
    parameter int DATA_WIDTH          = 32,
    parameter int PARTICLE_ID_WIDTH   = 20,
    parameter int NUM_FILTER          = 8,
    parameter int FILTER_ID_WIDTH     = 3,
    parameter int OUT_FIFO_DEPTH      = 4,
    parameter int OUT_FIFO_ADDR_WIDTH = 2
) (
    input  logic                                                          clk,
    input  logic                                                          rst,
    input  logic                                                          enable,
    input  logic [NUM_FILTER-1:0]                                         pair_available,
    input  logic [NUM_FILTER*pair_width(DATA_WIDTH,PARTICLE_ID_WIDTH)-1:0] pair_data,
    output logic [NUM_FILTER-1:0]                                         sel,
    output logic                                                          out_valid,
    input  logic                                                          out_ready,
    output logic [pair_width(DATA_WIDTH,PARTICLE_ID_WIDTH)-1:0]            out_pair,
    output logic [FILTER_ID_WIDTH-1:0]                                    out_filter_id,
    output logic                                                          idle
);

    localparam int PAIR_WIDTH  = pair_width(DATA_WIDTH, PARTICLE_ID_WIDTH);
    localparam int ENTRY_WIDTH = FILTER_ID_WIDTH + PAIR_WIDTH;

    localparam logic [OUT_FIFO_ADDR_WIDTH:0] c_DEPTH =
        (OUT_FIFO_ADDR_WIDTH + 1)'(OUT_FIFO_DEPTH);
    localparam logic [FILTER_ID_WIDTH-1:0]   c_LAST_ID = FILTER_ID_WIDTH'(NUM_FILTER - 1);

    logic [FILTER_ID_WIDTH-1:0]     rr_ptr_q, rr_ptr_d;
    logic [OUT_FIFO_ADDR_WIDTH:0]   reserved_q, reserved_d;
    logic                           grant_vld_q;
    logic [FILTER_ID_WIDTH-1:0]     grant_id_q;

    logic                           w_can_grant;
    logic [FILTER_ID_WIDTH-1:0]     w_winner;
    int                             w_best_dist;
    int                             w_dist;
    logic                           w_pop;
    logic [PAIR_WIDTH-1:0]          w_cap_pair;
    logic [ENTRY_WIDTH-1:0]         w_fifo_rd_data;
    logic                           w_fifo_empty;
    logic                           w_fifo_full;
    logic [OUT_FIFO_ADDR_WIDTH:0]   w_fifo_count;
    logic                           w_unused_fifo_status;

    // rst gates grants combinationally so sel drops the moment reset asserts,
    // not at the next edge.
    assign w_can_grant = rst & enable & (reserved_q < c_DEPTH) & (|pair_available);

    // Round-robin search: pick the available filter with the smallest
    // forward distance from rr_ptr (wrapping modulo NUM_FILTER).
    always_comb begin
        w_winner    = '0;
        w_best_dist = NUM_FILTER;
        w_dist      = 0;
        for (int i = 0; i < NUM_FILTER; i++) begin
            if (pair_available[i]) begin
                w_dist = i - int'(rr_ptr_q);
                if (w_dist < 0) begin
                    w_dist = w_dist + NUM_FILTER;
                end
                if (w_dist < w_best_dist) begin
                    w_best_dist = w_dist;
                    w_winner    = FILTER_ID_WIDTH'(i);
                end
            end
        end
    end

    always_comb begin
        sel = '0;
        for (int i = 0; i < NUM_FILTER; i++) begin
            sel[i] = w_can_grant && (w_winner == FILTER_ID_WIDTH'(i));
        end
    end

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (w_can_grant) begin
            rr_ptr_d = (w_winner == c_LAST_ID) ? '0 : w_winner + FILTER_ID_WIDTH'(1);
        end
    end

    assign w_pop = out_valid & out_ready;

    // A pop in this cycle only frees a credit for the next cycle's grant check.
    always_comb begin
        case ({w_can_grant, w_pop})
            2'b10:   reserved_d = reserved_q + (OUT_FIFO_ADDR_WIDTH + 1)'(1);
            2'b01:   reserved_d = reserved_q - (OUT_FIFO_ADDR_WIDTH + 1)'(1);
            default: reserved_d = reserved_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rr_ptr_q    <= '0;
            reserved_q  <= '0;
            grant_vld_q <= 1'b0;
            grant_id_q  <= '0;
        end else begin
            rr_ptr_q    <= rr_ptr_d;
            reserved_q  <= reserved_d;
            grant_vld_q <= w_can_grant;
            grant_id_q  <= w_winner;
        end
    end

    // Filter q is valid the cycle after its rdreq, so select it by the
    // registered grant id.
    always_comb begin
        w_cap_pair = '0;
        for (int i = 0; i < NUM_FILTER; i++) begin
            if (grant_id_q == FILTER_ID_WIDTH'(i)) begin
                w_cap_pair = pair_data[i*PAIR_WIDTH +: PAIR_WIDTH];
            end
        end
    end

    filter_arb_out_fifo #(
        .WIDTH      (ENTRY_WIDTH),
        .DEPTH      (OUT_FIFO_DEPTH),
        .ADDR_WIDTH (OUT_FIFO_ADDR_WIDTH)
    ) u_out_fifo (
        .clk       (clk),
        .rst       (rst),
        .wr_i      (grant_vld_q),
        .wr_data_i ({grant_id_q, w_cap_pair}),
        .rd_i      (w_pop),
        .rd_data_o (w_fifo_rd_data),
        .empty_o   (w_fifo_empty),
        .full_o    (w_fifo_full),
        .count_o   (w_fifo_count)
    );

    // The credit counter already prevents overflow, so full/count are spare.
    assign w_unused_fifo_status = w_fifo_full ^ (^w_fifo_count);

    // Outputs read zero whenever nothing is queued, including in reset.
    assign out_valid     = ~w_fifo_empty;
    assign out_pair      = out_valid ? w_fifo_rd_data[PAIR_WIDTH-1:0] : '0;
    assign out_filter_id = out_valid ? w_fifo_rd_data[ENTRY_WIDTH-1:PAIR_WIDTH] : '0;

    assign idle = ~rst | (~(|pair_available) & ~grant_vld_q & w_fifo_empty);

endmodule : filter_arbiter
`default_nettype wire

// File: tb/tb_filter_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_filter_arbiter
// Description : Self-checking bench for filter_arbiter. A queue-based
//               reference model predicts sel, output stream and idle each
//               cycle from the arbitration rules; directed scenarios are
//               followed by a randomized traffic phase.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_filter_arbiter;

    localparam int N     = 8;
    localparam int DW    = 32;
    localparam int PIDW  = 20;
    localparam int PAIRW = 2 * PIDW + 4 * DW;
    localparam int FW    = 3;
    localparam int DEPTH = 4;

    logic               clk;
    logic               rst;
    logic               enable;
    logic [N-1:0]       pair_available;
    logic [N*PAIRW-1:0] pair_data;
    logic [N-1:0]       sel;
    logic               out_valid;
    logic               out_ready;
    logic [PAIRW-1:0]   out_pair;
    logic [FW-1:0]      out_filter_id;
    logic               idle;

    filter_arbiter #(
        .DATA_WIDTH          (DW),
        .PARTICLE_ID_WIDTH   (PIDW),
        .NUM_FILTER          (N),
        .FILTER_ID_WIDTH     (FW),
        .OUT_FIFO_DEPTH      (DEPTH),
        .OUT_FIFO_ADDR_WIDTH (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .enable         (enable),
        .pair_available (pair_available),
        .pair_data      (pair_data),
        .sel            (sel),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_pair       (out_pair),
        .out_filter_id  (out_filter_id),
        .idle           (idle)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [FW-1:0]    id;
        logic [PAIRW-1:0] pair;
    } entry_t;

    // Reference model state
    entry_t       m_q[$];
    int           m_rr;
    int           m_res;
    bit           m_pend;
    int           m_pend_id;
    int           cnt[N];
    bit           use_cnt;
    logic [N-1:0] avail_direct;

    int n_pass;
    int n_fail;
    int n_total;

    task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        m_q.delete();
        m_rr      = 0;
        m_res     = 0;
        m_pend    = 0;
        m_pend_id = 0;
    endtask

    task automatic step();
        bit           can;
        int           winner;
        logic [N-1:0] exp_sel;
        bit           exp_valid;
        entry_t       head;

        for (int w = 0; w < (N * PAIRW) / 32; w++) begin
            pair_data[w*32 +: 32] = $urandom;
        end
        if (use_cnt) begin
            for (int i = 0; i < N; i++) pair_available[i] = (cnt[i] > 0);
        end else begin
            pair_available = avail_direct;
        end
        #1;

        if (!rst) model_clear();

        winner = 0;
        for (int k = N - 1; k >= 0; k--) begin
            if (pair_available[(m_rr + k) % N]) winner = (m_rr + k) % N;
        end
        can       = rst && enable && (m_res < DEPTH) && (pair_available != '0);
        exp_sel   = can ? (N'(1) << winner) : '0;
        exp_valid = (m_q.size() > 0);
        head      = exp_valid ? m_q[0] : '0;

        chk("sel",           200'(sel),            200'(exp_sel));
        chk("out_valid",     200'(out_valid),      200'(exp_valid));
        chk("out_pair",      200'(out_pair),       200'(head.pair));
        chk("out_filter_id", 200'(out_filter_id),  200'(head.id));
        chk("idle",          200'(idle),
            200'(!rst || (pair_available == '0 && !m_pend && m_q.size() == 0)));
        chk("rr_ptr",        200'(dut.rr_ptr_q),   200'(m_rr));
        chk("reserved",      200'(dut.reserved_q), 200'(m_res));
        chk("reserved_le_depth", 200'(dut.reserved_q <= DEPTH), 200'(1));

        if (rst) begin
            if (exp_valid && out_ready) void'(m_q.pop_front());
            if (m_pend) begin
                entry_t e;
                e.id   = FW'(m_pend_id);
                e.pair = pair_data[m_pend_id*PAIRW +: PAIRW];
                m_q.push_back(e);
            end
            m_res     = m_res + int'(can) - int'(exp_valid && out_ready);
            m_pend    = can;
            m_pend_id = winner;
            if (can) begin
                m_rr = (winner + 1) % N;
                if (use_cnt) cnt[winner]--;
            end
        end

        @(posedge clk);
        #1;
    endtask

    task automatic steps(input int n);
        for (int s = 0; s < n; s++) step();
    endtask

    initial begin
        n_pass  = 0;
        n_fail  = 0;
        n_total = 0;
        model_clear();
        for (int i = 0; i < N; i++) cnt[i] = 0;
        pair_data = '0;

        // 1: reset with everything available, then release
        rst          = 1'b0;
        enable       = 1'b1;
        out_ready    = 1'b1;
        use_cnt      = 1'b0;
        avail_direct = 8'hFF;
        steps(3);
        rst = 1'b1;

        // 2: all available, full throughput rotation 0..7 and wrap
        steps(14);

        // 3: only filter 5, with 3 pairs
        avail_direct = 8'h00;
        steps(4);
        use_cnt = 1'b1;
        cnt[5]  = 3;
        steps(8);

        // 4: back-pressure fills credits, then drains and resumes
        use_cnt      = 1'b0;
        avail_direct = 8'hFF;
        out_ready    = 1'b0;
        steps(8);
        out_ready = 1'b1;
        steps(8);

        // 5: wrap from rr_ptr=5 with filters 7 and 4 available
        rst = 1'b0;
        steps(1);
        rst          = 1'b1;
        avail_direct = 8'h00;
        steps(1);
        avail_direct = 8'h10;
        steps(1);
        avail_direct = 8'h90;
        steps(2);
        avail_direct = 8'h00;
        steps(3);

        // 6: reset with pairs queued discards them
        avail_direct = 8'hFF;
        out_ready    = 1'b0;
        steps(5);
        rst = 1'b0;
        steps(1);
        rst          = 1'b1;
        avail_direct = 8'h00;
        out_ready    = 1'b1;
        steps(4);

        // 7: randomized traffic with filter buffer occupancy model
        use_cnt = 1'b1;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        for (int c = 0; c < 400; c++) begin
            enable    = ($urandom_range(0, 9) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            for (int i = 0; i < N; i++) begin
                if (cnt[i] == 0 && $urandom_range(0, 5) == 0) cnt[i] = $urandom_range(1, 4);
            end
            step();
        end
        enable = 1'b1;
        out_ready = 1'b1;
        for (int i = 0; i < N; i++) cnt[i] = 0;
        steps(8);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule : tb_filter_arbiter
`default_nettype wire
